// File: rtl/lnvd_adc_pkg.sv
// Shared constants and state encoding for the LNVD ADC four-channel averager.
package lnvd_adc_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int NUM_CH     = 4;

    typedef enum logic {
        ST_SKIP = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/lnvd_avg_chan.sv
// One channel of the boxcar averager: accumulator, clip-pending flag and held output.
module lnvd_avg_chan #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              close,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg,
    output logic              clip
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic [ACC_W-1:0] r_acc;
    logic             r_clip_pend;
    logic [DATA_W-1:0] r_avg;
    logic             r_clip;

    logic [ACC_W-1:0] w_sum;
    logic             w_full;

    assign w_sum  = r_acc + {{LOG2_N{1'b0}}, din};
    assign w_full = (din == {DATA_W{1'b1}});

    // The closing sample goes into the output only; the accumulator restarts empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_clip_pend <= 1'b0;
            r_avg       <= '0;
            r_clip      <= 1'b0;
        end else if (sample_en) begin
            if (close) begin
                r_avg       <= w_sum[ACC_W-1:LOG2_N];
                r_clip      <= r_clip_pend | w_full;
                r_acc       <= '0;
                r_clip_pend <= 1'b0;
            end else begin
                r_acc       <= w_sum;
                r_clip_pend <= r_clip_pend | w_full;
            end
        end
    end

    assign avg  = r_avg;
    assign clip = r_clip;

endmodule

// File: rtl/lnvd_adc_avg4.sv
// Four-channel boxcar averager / decimator: discards SKIP settling samples, then
// emits one averaged word per channel every 2^LOG2_N accepted samples.
module lnvd_adc_avg4
    import lnvd_adc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = 4,
    parameter int SKIP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] ch_a,
    input  logic [DATA_W-1:0] ch_b,
    input  logic [DATA_W-1:0] ch_c,
    input  logic [DATA_W-1:0] ch_d,
    output logic [DATA_W-1:0] avg_a,
    output logic [DATA_W-1:0] avg_b,
    output logic [DATA_W-1:0] avg_c,
    output logic [DATA_W-1:0] avg_d,
    output logic              avg_valid,
    output logic [NUM_CH-1:0] clip,
    output logic              busy_skip
);

    localparam int                SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [LOG2_N-1:0] CNT_LAST  = '1;
    localparam state_t            ST_RESET  = (SKIP > 0) ? ST_SKIP : ST_ACC;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [LOG2_N-1:0] r_cnt;
    logic              r_avg_valid;
    logic              w_accept;
    logic              w_skip_adv;
    logic              w_close;

    logic [DATA_W-1:0] w_din [NUM_CH];
    logic [DATA_W-1:0] w_avg [NUM_CH];
    logic [NUM_CH-1:0] w_clip;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RESET;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_skip_adv  = 1'b0;
        case (r_state)
            ST_SKIP: begin
                if (sample_valid) begin
                    w_skip_adv = 1'b1;
                    if (r_skip_cnt == SKIP_LAST) w_state_nxt = ST_ACC;
                end
            end
            ST_ACC:  w_accept = sample_valid;
            default: w_state_nxt = ST_RESET;
        endcase
    end

    assign w_close = w_accept && (r_cnt == CNT_LAST);

    // Sample count wraps naturally at N, which is what clears it on window close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt  <= '0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            if (w_skip_adv) r_skip_cnt <= r_skip_cnt + 1'b1;
            if (w_accept)   r_cnt      <= r_cnt + 1'b1;
            r_avg_valid <= w_close;
        end
    end

    assign w_din[0] = ch_a;
    assign w_din[1] = ch_b;
    assign w_din[2] = ch_c;
    assign w_din[3] = ch_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        lnvd_avg_chan #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sample_en (w_accept),
            .close     (w_close),
            .din       (w_din[k]),
            .avg       (w_avg[k]),
            .clip      (w_clip[k])
        );
    end

    assign avg_a     = w_avg[0];
    assign avg_b     = w_avg[1];
    assign avg_c     = w_avg[2];
    assign avg_d     = w_avg[3];
    assign clip      = w_clip;
    assign avg_valid = r_avg_valid;
    assign busy_skip = (r_state == ST_SKIP);

endmodule
